// File: rtl/wbl_keygen_seq.sv
// Sequential WBL_DATA generator: iterative AES-128 key expansion into an 11-entry
// round-key bank, then a valid/ready stream of WBL words per row-address request.
module wbl_keygen_seq #(
    parameter int ADDR_W   = 6,
    parameter int INV_BASE = 32,
    parameter int N_WORDS  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [127:0]      key_in,
    output logic              key_load_rdy,
    output logic              key_valid,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              wbl_valid,
    input  logic              wbl_ready,
    output logic [63:0]       wbl_data,
    output logic [3:0]        wbl_idx,
    output logic              wbl_last
);

    typedef enum logic [1:0] {K_EMPTY, K_EXPAND, K_VALID} key_state_e;
    typedef enum logic {R_IDLE, R_STREAM} req_state_e;

    localparam logic [3:0]        LAST_BEAT = 4'(N_WORDS - 1);
    localparam logic [ADDR_W-1:0] INV0      = ADDR_W'(INV_BASE);
    localparam logic [ADDR_W-1:0] INV1      = ADDR_W'(INV_BASE + 1);
    localparam logic [ADDR_W-1:0] INV2      = ADDR_W'(INV_BASE + 2);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX_TBL[11'd2047 - {x, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    key_state_e   key_state_q, key_state_d;
    req_state_e   req_state_q, req_state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] rk_q [11];
    logic [127:0] rk_d [11];
    logic         key_valid_q, key_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]   beat_q, beat_d;
    logic [31:0]  sb_q, sb_d;

    logic         req_acc, key_acc, stream_last;
    logic [127:0] prev_rk, next_rk;
    logic [31:0]  sb_in, sb_out, temp;
    logic [7:0]   a8;
    logic [1:0]   fsel;
    logic         finv, fen;
    logic [63:0]  word;

    assign key_load_rdy = (key_state_q != K_EXPAND) && (req_state_q == R_IDLE);
    assign req_ready    = key_valid_q && (req_state_q == R_IDLE);
    assign req_acc      = req_valid && req_ready;
    // A request accepted in the same cycle keeps the current bank; the key load is dropped.
    assign key_acc      = key_load && key_load_rdy && !req_acc;
    assign stream_last  = beat_q == LAST_BEAT;

    // The single 4-byte S-box serves key expansion while expanding, address bytes otherwise.
    always_comb begin
        prev_rk = rk_q[rnd_q - 4'd1];
        a8      = {2'b00, req_addr[5:0]};
        if (key_state_q == K_EXPAND) begin
            sb_in = {prev_rk[23:0], prev_rk[31:24]};
        end else begin
            sb_in = {8'hc0 + a8, 8'h80 + a8, 8'h40 + a8, a8};
        end
        sb_out = {sbox(sb_in[31:24]), sbox(sb_in[23:16]), sbox(sb_in[15:8]), sbox(sb_in[7:0])};
        temp   = sb_out ^ {rcon(rnd_q), 24'h0};
        next_rk[127:96] = prev_rk[127:96] ^ temp;
        next_rk[95:64]  = prev_rk[95:64]  ^ next_rk[127:96];
        next_rk[63:32]  = prev_rk[63:32]  ^ next_rk[95:64];
        next_rk[31:0]   = prev_rk[31:0]   ^ next_rk[63:32];
    end

    always_comb begin
        key_state_d = key_state_q;
        rnd_d       = rnd_q;
        rk_d        = rk_q;
        case (key_state_q)
            K_EMPTY, K_VALID: begin
                if (key_acc) begin
                    key_state_d = K_EXPAND;
                    rk_d[0]     = key_in;
                    rnd_d       = 4'd1;
                end
            end
            K_EXPAND: begin
                rk_d[rnd_q] = next_rk;
                if (rnd_q == 4'd10) begin
                    key_state_d = K_VALID;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: key_state_d = K_EMPTY;
        endcase
        key_valid_d = (key_state_q == K_VALID) && (key_state_d == K_VALID);
    end

    always_comb begin
        req_state_d = req_state_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        sb_d        = sb_q;
        if (req_state_q == R_IDLE) begin
            if (req_acc) begin
                req_state_d = R_STREAM;
                addr_d      = req_addr;
                beat_d      = 4'd0;
                sb_d        = sb_out;
            end
        end else if (wbl_ready) begin
            if (stream_last) begin
                req_state_d = R_IDLE;
            end else begin
                beat_d = beat_q + 4'd1;
            end
        end
    end

    always_comb begin
        fsel = 2'd0;
        finv = 1'b0;
        fen  = 1'b1;
        if (addr_q == '0) begin
            fsel = 2'd0;
        end else if (addr_q == ADDR_W'(1)) begin
            fsel = 2'd1;
        end else if (addr_q == ADDR_W'(2)) begin
            fsel = 2'd2;
        end else if (addr_q == INV0) begin
            fsel = 2'd0;
            finv = 1'b1;
        end else if (addr_q == INV1) begin
            fsel = 2'd1;
            finv = 1'b1;
        end else if (addr_q == INV2) begin
            fsel = 2'd2;
            finv = 1'b1;
        end else begin
            fen = 1'b0;
        end
    end

    // Beat k maps to byte half beat_q[3] and bit position beat_q[2:0] of each round key.
    always_comb begin
        logic [15:0] pair;
        logic [7:0]  byt;
        logic [10:0] rb;
        logic [3:0]  fld;
        logic [7:0]  seg;
        word = '0;
        pair = '0;
        byt  = '0;
        rb   = '0;
        fld  = '0;
        seg  = '0;
        for (int r = 0; r < 8; r++) begin
            for (int n = 0; n < 11; n++) begin
                pair        = rk_q[n][127 - 16*r -: 16];
                byt         = beat_q[3] ? pair[7:0] : pair[15:8];
                rb[10 - n]  = byt[beat_q[2:0]];
            end
            case (fsel)
                2'd0:    fld = rb[10:7];
                2'd1:    fld = rb[6:3];
                default: fld = {rb[2:0], 1'b0};
            endcase
            if (finv) fld = ~fld;
            if (!fen) fld = 4'd0;
            seg = {fld, sb_q[31 - r], sb_q[23 - r], sb_q[15 - r], sb_q[7 - r]};
            for (int c = 0; c < 8; c++) begin
                word[63 - 8*c - r] = seg[7 - c];
            end
        end
    end

    assign key_valid = key_valid_q;
    assign wbl_valid = req_state_q == R_STREAM;
    assign wbl_data  = wbl_valid ? word : 64'd0;
    assign wbl_idx   = beat_q;
    assign wbl_last  = wbl_valid && stream_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state_q <= K_EMPTY;
            req_state_q <= R_IDLE;
            rnd_q       <= 4'd0;
            key_valid_q <= 1'b0;
            addr_q      <= '0;
            beat_q      <= 4'd0;
            sb_q        <= 32'd0;
            for (int n = 0; n < 11; n++) begin
                rk_q[n] <= 128'd0;
            end
        end else begin
            key_state_q <= key_state_d;
            req_state_q <= req_state_d;
            rnd_q       <= rnd_d;
            key_valid_q <= key_valid_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            sb_q        <= sb_d;
            rk_q        <= rk_d;
        end
    end

endmodule

// File: doc/wbl_keygen_seq.md
Name: wbl_keygen_seq

Overview:
Sequential, parametrised generator of WBL_DATA words for the DRAM-CIM AES array.
- Expands a 128-bit AES key iteratively (one round key per clock) into an internal bank of 11 round keys.
- On each address request, streams the words WBL1..WBL16 one per beat over a valid/ready interface.
- Replaces the flat combinational generator: round-key logic is shared across rounds, a key cache prevents re-expansion per address, and output back-pressure is supported.

Parameters:
ADDR_W, 6, width of req_addr.
INV_BASE, 32, first address of the inverted-field group; the group covers INV_BASE..INV_BASE+2.
N_WORDS, 16, beats per request; legal values are 8 (WBL1..WBL8 only) or 16.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
key_load  in  1  start expansion of key_in; accepted only while key_load_rdy=1
key_in  in  128  AES-128 key, word0 = key_in[127:96]
key_load_rdy  out  1  high in K_EMPTY/K_VALID when the request FSM is R_IDLE
key_valid  out  1  round-key bank is complete for the last loaded key
req_valid  in  1  address request
req_addr  in  ADDR_W  WBL row address
req_ready  out  1  key_valid & R_IDLE
wbl_valid  out  1  output beat valid
wbl_ready  in  1  sink accepts beat
wbl_data  out  64  WBL word
wbl_idx  out  4  beat number, 0..N_WORDS-1 (0 = WBL1)
wbl_last  out  1  final beat of request

Behaviour:
Reset: all outputs 0 except key_load_rdy=1. Key FSM=K_EMPTY, request FSM=R_IDLE, round-key bank cleared. Reset mid-expansion or mid-stream aborts immediately.

Key FSM:
- K_EMPTY/K_VALID + key_load & key_load_rdy -> K_EXPAND. rk[0]=key_in is captured; round counter=1; key_valid drops next cycle.
- K_EXPAND: each cycle computes rk[n] from rk[n-1] using standard AES-128 (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36). The datapath has one shared 4-byte S-box instance.
- After rk[10] is written -> K_VALID. key_valid is high exactly 11 cycles after the accepting edge.
- key_load during K_EXPAND or R_STREAM is ignored (key_load_rdy=0).

Request FSM:
- R_IDLE + req_valid & req_ready -> R_STREAM. Latches req_addr, beat=0, and the 4 S-box bytes s0..s3 = S(0xC0+a), S(0x80+a), S(0x40+a), S(a), with additions mod 256 on the low 6 address bits.
- First wbl_valid occurs the cycle after acceptance.
- Beat advances on wbl_valid & wbl_ready. wbl_data, wbl_idx and wbl_last are held stable while stalled.
- wbl_last=1 when beat=N_WORDS-1. Its handshake returns the FSM to R_IDLE; req_ready is high again the next cycle, with no back-to-back accept in that cycle.

Word formation (beat k):
- Internal index j = 7-k for k<8, else 23-k.
- Byte half: j<8 selects even bytes, else odd bytes. Bit position b = 7-(j mod 8).
- For row r=0..7 and round n=0..10, bit[10-n] = bit b of byte (2r, or 2r+1 for odd) of rk[n], where byte 0 is the MSB.
- Field f (4 bits) per address:
  - a=0: bit[10:7]
  - a=1: bit[6:3]
  - a=2: {bit[2:0],0}
  - a=INV_BASE+0..2: bitwise inverse of the matching field
  - otherwise: 0
- Row segment (10 bits) = {f, s0[7-r], s1[7-r], s2[7-r], s3[7-r], 00}.
- Output byte c (c=0 is MSB of wbl_data, c=0..7) = {seg0[9-c], ..., seg7[9-c]}. Segment bits [1:0] are never emitted.
- The field is computed combinationally from the stored bank and the beat counter; no per-beat extra latency.

Test Plan:
- Reset mid-expansion -> key_valid=0, wbl_valid=0, key_load_rdy=1 on the first cycle after reset release.
- Load key 2b7e151628aed2a6abf7158809cf4f3c -> key_valid rises 11 cycles after accept. The internal rk[10] is d014f9a8c9ee2589e13f0cc8b6630ca6.
- Same key, addr 4 -> 16 beats, every wbl_data=0x000000001c5f1bf2; wbl_last only on wbl_idx=15.
- Same key, addr 0 -> beat 7 (WBL8) bits[63:56]=0x18, bits[31:0]=0xbacd0963. Addr 32 -> the same beat has bits[63:56]=0xe7.
- Addr 2 -> every beat has bits[39:32]=0x00. Addr 34 -> bits[39:32]=0xff.
- Random wbl_ready stalls at N_WORDS=16 -> data and idx held while stalled. No beat is dropped or duplicated. key_load and req_valid are ignored mid-stream; the stream then completes and accepts the next request.
